// File: rtl/mdu_seq.sv
// Sequential RISC-V M-extension multiply/divide unit.
// Multiplies with a 32-step radix-2 shift-add. Divides with a 32-step restoring divider.
// Divide-by-zero and signed overflow are resolved in one cycle.
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   i_start      - valid M-type op in EX, held high by the stalled pipeline until done
//   i_func3      - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   i_rs1_data   - operand A (multiplicand / dividend)
//   i_rs2_data   - operand B (multiplier / divisor)
//   i_flush      - abort the operation in EX
//   o_stall      - freeze IF/ID/EX while the operation is incomplete
//   o_busy       - FSM not idle
//   o_done       - one-cycle strobe, o_result valid
//   o_result     - M-extension result
module mdu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [2:0] F3Mul    = 3'd0;
  localparam logic [2:0] F3Mulh   = 3'd1;
  localparam logic [2:0] F3Mulhsu = 3'd2;
  localparam logic [2:0] F3Mulhu  = 3'd3;
  localparam logic [2:0] F3Div    = 3'd4;
  localparam logic [2:0] F3Divu   = 3'd5;
  localparam logic [2:0] F3Rem    = 3'd6;
  localparam logic [2:0] F3Remu   = 3'd7;

  state_e      r_state, w_state_n;
  logic [2:0]  r_func3;
  logic [4:0]  r_cnt;
  // Mul: r_hi:r_lo is the product accumulator, r_lo starts as the multiplier.
  // Div: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_opb;    // multiplicand magnitude or divisor magnitude
  logic        r_neg_q;  // negate product / quotient
  logic        r_neg_r;  // negate remainder
  logic [31:0] r_result;

  // Operand decode at issue
  logic        w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic        w_is_div, w_div0, w_ovf, w_special;
  logic [31:0] w_special_res;
  logic        w_launch;

  assign w_a_signed = (i_func3 == F3Mulh) || (i_func3 == F3Mulhsu) ||
                      (i_func3 == F3Div)  || (i_func3 == F3Rem);
  assign w_b_signed = (i_func3 == F3Mulh) || (i_func3 == F3Div) || (i_func3 == F3Rem);
  assign w_a_neg    = w_a_signed & i_rs1_data[31];
  assign w_b_neg    = w_b_signed & i_rs2_data[31];
  // 0x80000000 negates to itself, which is its correct unsigned magnitude
  assign w_a_mag    = w_a_neg ? (32'd0 - i_rs1_data) : i_rs1_data;
  assign w_b_mag    = w_b_neg ? (32'd0 - i_rs2_data) : i_rs2_data;

  assign w_is_div   = i_func3[2];
  assign w_div0     = w_is_div & (i_rs2_data == 32'd0);
  assign w_ovf      = ((i_func3 == F3Div) || (i_func3 == F3Rem)) &&
                      (i_rs1_data == 32'h8000_0000) && (i_rs2_data == 32'hFFFF_FFFF);
  assign w_special  = w_div0 | w_ovf;

  // func3[1] selects the remainder flavour among the divide ops
  always_comb begin
    w_special_res = 32'd0;
    if (w_div0) begin
      w_special_res = i_func3[1] ? i_rs1_data : 32'hFFFF_FFFF;
    end else if (w_ovf) begin
      w_special_res = i_func3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  assign w_launch = (r_state == StIdle) & i_start & ~i_flush;

  // One iteration step
  logic        w_op_div;
  logic [32:0] w_add;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic [31:0] w_hi_n, w_lo_n;

  assign w_op_div = r_func3[2];
  assign w_add    = {1'b0, r_hi} + {1'b0, r_opb};
  assign w_shift  = {r_hi, r_lo[31]};
  assign w_diff   = w_shift - {1'b0, r_opb};

  always_comb begin
    w_hi_n = r_hi;
    w_lo_n = r_lo;
    if (w_op_div) begin
      if (!w_diff[32]) begin
        w_hi_n = w_diff[31:0];
        w_lo_n = {r_lo[30:0], 1'b1};
      end else begin
        w_hi_n = w_shift[31:0];
        w_lo_n = {r_lo[30:0], 1'b0};
      end
    end else if (r_lo[0]) begin
      {w_hi_n, w_lo_n} = {w_add, r_lo[31:1]};
    end else begin
      {w_hi_n, w_lo_n} = {1'b0, r_hi, r_lo[31:1]};
    end
  end

  // Final sign fix-up and result select, evaluated on the last step
  logic [63:0] w_prod, w_prod_s;
  logic [31:0] w_quo, w_rem, w_final;

  assign w_prod   = {w_hi_n, w_lo_n};
  assign w_prod_s = r_neg_q ? (64'd0 - w_prod) : w_prod;
  assign w_quo    = r_neg_q ? (32'd0 - w_lo_n) : w_lo_n;
  assign w_rem    = r_neg_r ? (32'd0 - w_hi_n) : w_hi_n;

  always_comb begin
    w_final = 32'd0;
    unique case (r_func3)
      F3Mul:                    w_final = w_prod_s[31:0];
      F3Mulh, F3Mulhsu, F3Mulhu: w_final = w_prod_s[63:32];
      F3Div, F3Divu:            w_final = w_quo;
      F3Rem, F3Remu:            w_final = w_rem;
      default:                  w_final = 32'd0;
    endcase
  end

  // Next state and outputs
  always_comb begin
    w_state_n = r_state;
    o_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_launch) w_state_n = w_special ? StDone : StCalc;
      end
      StCalc: begin
        if (r_cnt == 5'd31) w_state_n = StDone;
      end
      StDone: begin
        o_done    = ~i_flush;
        w_state_n = StIdle;
      end
      default: w_state_n = StIdle;
    endcase
    if (i_flush) w_state_n = StIdle;
  end

  assign o_stall  = w_launch | (r_state == StCalc);
  assign o_busy   = (r_state != StIdle);
  assign o_result = r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_func3  <= 3'd0;
      r_cnt    <= 5'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_opb    <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_state <= w_state_n;
      if (w_launch) begin
        r_func3 <= i_func3;
        r_cnt   <= 5'd0;
        r_hi    <= 32'd0;
        r_lo    <= w_is_div ? w_a_mag : w_b_mag;
        r_opb   <= w_is_div ? w_b_mag : w_a_mag;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        if (w_special) r_result <= w_special_res;
      end else if ((r_state == StCalc) && !i_flush) begin
        r_cnt <= r_cnt + 5'd1;
        r_hi  <= w_hi_n;
        r_lo  <= w_lo_n;
        if (r_cnt == 5'd31) r_result <= w_final;
      end
    end
  end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset; assertion forces reset state immediately, release synchronous to clk.
REQ-003 start  in  1  EX-stage instruction is a valid M-type R-op (is_mtype=1, OP opcode); held high by the stalled pipeline until done.
REQ-004 func3  in  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 rs1_data  in  32  operand A (multiplicand/dividend).
REQ-006 rs2_data  in  32  operand B (multiplier/divisor).
REQ-007 flush  in  1  pipeline flush of EX stage; aborts any operation.
REQ-008 stall  out  1  freeze IF/ID/EX while operation incomplete.
REQ-009 busy  out  1  FSM not IDLE.
REQ-010 done  out  1  one-cycle strobe; result valid this cycle.
REQ-011 result  out  32  RISC-V M-extension result; valid only while done=1.

Function
REQ-012 FSM states SHALL be IDLE, CALC, DONE.
REQ-013 IDLE: start=1 and flush=0 -> latch func3, operands and 5-bit iteration counter=0; go CALC, or go DONE directly for special cases (REQ-019/020).
REQ-014 CALC: one radix-2 step per cycle; counter increments; after 32nd step (counter=31 at the edge) go DONE.
REQ-015 DONE: done=1, result driven from internal register, then unconditionally IDLE; start ignored in DONE (belongs to the finishing instruction).
REQ-016 stall SHALL equal (start & state==IDLE & ~flush) | (state==CALC); stall=0 in DONE so the instruction retires that cycle.
REQ-017 Latency: start sampled in cycle 0 -> done=1 in cycle 33 for iterative ops; cycle 1 for special cases.
REQ-018 Multiply: unsigned shift-add on magnitudes; operand signedness per func3 (MULH both signed, MULHSU rs1 signed only, MULHU/MUL unsigned magnitude path); 64-bit product negated if sign mismatch; MUL returns [31:0], MULH/MULHSU/MULHU return [63:32].
REQ-019 Divide by zero (rs2=0): DIV/DIVU result 0xFFFFFFFF; REM/REMU result rs1; no iteration.
REQ-020 Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV result 0x80000000, REM result 0; no iteration.
REQ-021 Divide otherwise: restoring division on magnitudes; quotient negated if operand signs differ (signed ops); remainder takes sign of dividend.
REQ-022 flush=1 in any state SHALL return FSM to IDLE next edge with done=0 for that op; flush has priority over start and over DONE completion.
REQ-023 result SHALL hold its last value outside done; done never asserted in IDLE or CALC.

Reset
REQ-024 rst_n=0 SHALL force state=IDLE, counter=0, result register=0; stall=busy=done=0 (stall may rise only via start after release).
REQ-025 Reset mid-CALC SHALL abandon the operation; no done strobe after release.

Verification
REQ-026 MUL rs1=0xFFFFFFFF(-1), rs2=3 -> done in cycle 33, result 0xFFFFFFFD; stall high cycles 0-32, low cycle 33.
REQ-027 MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-028 DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF in cycle 1.
REQ-029 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in cycle 1; REM -> 0.
REQ-030 flush asserted cycle 10 of CALC -> IDLE next cycle, no done; new start next cycle completes normally with correct result.
REQ-031 rst_n low during cycle 15 of CALC -> outputs zero immediately, busy=0; no done after release until a new start.
